// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// The optional macro DIV_SIGNED_EN (used in div_seq_ctrl) enables signed operands.
package div_pkg;

  // Controller states. FIXUP is reachable only in the signed build.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // Quotient returned on a zero divisor (all ones; sliced to the operand width).
  localparam logic [15:0] DIV_ZERO_Q = 16'hFFFF;

  // Width of the iteration counter: must hold the value w itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/add_sub_w.sv
// N-bit ripple add/subtract. b is XORed with c_in, so c_in=1 gives a - b
// (two's complement), and c_out=1 then means no borrow.
module add_sub_w #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N-1:0] b_eff;

  assign b_eff = b ^ {N{c_in}};

  // Ripple the carry bit by bit; a block-local carry keeps the chain acyclic.
  always_comb begin
    logic c;
    sum = '0;
    c   = c_in;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ c;
      c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one trial subtraction per clock on a single
// shared add/sub unit. Results are held until the next accepted start.
// Optional macro DIV_SIGNED_EN: two's complement operands, truncating
// division, one extra FIXUP cycle that restores the result signs.
//
// Handshake: start is sampled only on a rising edge where ready=1; a start
// seen while busy or in DONE is dropped, not queued. done is a one-cycle
// pulse and quotient/remainder/div_by_zero are valid from that cycle on.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output div_state_t   dbg_state,
  output logic [W:0]   dbg_partial
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_t    state_q, state_d;
  logic [W:0]    r_q, r_d;      // partial remainder
  logic [W-1:0]  q_q, q_d;      // shifting dividend / quotient
  logic [W-1:0]  dv_q, dv_d;    // divisor (magnitude in the signed build)
  logic [CW-1:0] cnt_q, cnt_d;  // remaining CALC cycles
  logic          dz_q, dz_d;    // zero-divisor operation in flight

`ifdef DIV_SIGNED_EN
  logic          q_neg_q, q_neg_d;  // operand signs differ
  logic          r_neg_q, r_neg_d;  // dividend was negative
`endif

  // Shared add/sub datapath
  logic [W:0]    as_a, as_b, as_sum;
  logic          as_cin, as_cout;

  add_sub_w #(.N(W + 1)) u_add_sub (
    .a     (as_a),
    .b     (as_b),
    .c_in  (as_cin),
    .sum   (as_sum),
    .c_out (as_cout)
  );

  // Next-state, datapath steering and register next values.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
`endif
    as_a    = '0;
    as_b    = '0;
    as_cin  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Keep the raw dividend in Q: it becomes the remainder.
            state_d = DONE;
            dz_d    = 1'b1;
            q_d     = dividend;
            r_d     = '0;
            dv_d    = '0;
            cnt_d   = '0;
          end else begin
            state_d = CALC;
            dz_d    = 1'b0;
            r_d     = '0;
            cnt_d   = CNT_LOAD;
`ifdef DIV_SIGNED_EN
            // Adder is idle here, so it forms the dividend magnitude (0 - x).
            as_b    = {1'b0, dividend};
            as_cin  = 1'b1;
            q_d     = dividend[W-1] ? as_sum[W-1:0] : dividend;
            dv_d    = divisor[W-1] ? (~divisor + W'(1)) : divisor;
            q_neg_d = dividend[W-1] ^ divisor[W-1];
            r_neg_d = dividend[W-1];
`else
            q_d     = dividend;
            dv_d    = divisor;
`endif
          end
        end
      end

      CALC: begin
        // Trial subtract of the divisor from the shifted partial remainder.
        as_a   = {r_q[W-1:0], q_q[W-1]};
        as_b   = {1'b0, dv_q};
        as_cin = 1'b1;
        if (as_cout) begin
          r_d = as_sum;
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          r_d = as_a;
          q_d = {q_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
`ifdef DIV_SIGNED_EN
          state_d = FIXUP;
`else
          state_d = DONE;
`endif
        end
      end

      FIXUP: begin
`ifdef DIV_SIGNED_EN
        // Adder negates the quotient; the remainder takes the dividend's sign.
        as_b   = {1'b0, q_q};
        as_cin = 1'b1;
        if (q_neg_q) q_d = as_sum[W-1:0];
        if (r_neg_q) r_d = {1'b0, ~r_q[W-1:0] + W'(1)};
        state_d = DONE;
`else
        state_d = IDLE;
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
`endif
    end
  end

  // Result registers load on the edge into DONE, so they are valid with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state_d == DONE) begin
      quotient    <= dz_d ? DIV_ZERO_Q[W-1:0] : q_d;
      remainder   <= dz_d ? q_d : r_d[W-1:0];
      div_by_zero <= dz_d;
    end
  end

  // Status decode from the state register.
  always_comb begin
    ready       = (state_q == IDLE);
    busy        = (state_q == CALC) || (state_q == FIXUP);
    done        = (state_q == DONE);
    dbg_state   = state_q;
    dbg_partial = r_q;
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl (W=4). Define DIV_SIGNED_EN for the
// signed build; the reference model follows the same macro.
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int W     = 4;
`ifdef DIV_SIGNED_EN
  localparam int LAT_N = W + 2;
`else
  localparam int LAT_N = W + 1;
`endif
  localparam int LIMIT = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         ready, busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  div_state_t   dbg_state;
  logic [W:0]   dbg_partial;

  logic [2*W:0] exp_q[$];
  int           pass_cnt  = 0;
  int           total_cnt = 0;

  div_seq_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state),
    .dbg_partial (dbg_partial)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: {div_by_zero, quotient, remainder}
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] qv, rv;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIV_SIGNED_EN
    begin
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      qv = 32'(sa / sb);
      rv = 32'(sa % sb);
    end
`else
    qv = 32'(a) / 32'(b);
    rv = 32'(a) % 32'(b);
`endif
    return {1'b0, qv[W-1:0], rv[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Driver: called at a negedge; start is held for exactly one rising edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    check("ready_at_start", 32'(ready), 32'(1));
    if (push) exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done (bounded), check latency, pop and compare, check single pulse.
  task automatic wait_done(input int exp_lat, input int lat_start, input string tag);
    int lat;
    logic [2*W:0] exp;
    lat = lat_start;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'(1));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (done === 1'b1) begin
      check({tag, "_busy_in_done"}, 32'(busy), 32'(0));
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check({tag, "_result"}, 32'({div_by_zero, quotient, remainder}), 32'(exp));
      end else begin
        check({tag, "_sb_nonempty"}, 32'(exp_q.size()), 32'(1));
      end
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'(0));
    check({tag, "_ready_after"}, 32'(ready), 32'(1));
  endtask

  initial begin
    int a, b;
    bit saw_done;

    // Reset
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_outputs", 32'({div_by_zero, quotient, remainder}), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic and edge divides
    launch(4'd13, 4'd3, 1'b1);
    wait_done(LAT_N, 1, "div_13_3");
    launch(4'd15, 4'd1, 1'b1);
    wait_done(LAT_N, 1, "div_15_1");
    launch(4'd2, 4'd7, 1'b1);
    wait_done(LAT_N, 1, "div_2_7");
    launch(4'd15, 4'd15, 1'b1);
    wait_done(LAT_N, 1, "div_15_15");

    // Zero divisor
    launch(4'd5, 4'd0, 1'b1);
    wait_done(1, 1, "div_5_0");

    // Start while busy is ignored
    launch(4'd9, 4'd2, 1'b1);
    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    check("overlap_busy", 32'(busy), 32'(1));
    check("overlap_ready", 32'(ready), 32'(0));
    @(negedge clk);
    start = 1'b0;
    wait_done(LAT_N, 3, "div_9_2_overlap");
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    // Back-to-back: start in the first IDLE cycle after done
    launch(4'd14, 4'd3, 1'b1);
    wait_done(LAT_N, 1, "div_14_3_b2b");

    // Reset mid-operation: no done, outputs cleared
    launch(4'd13, 4'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'(1));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_outputs", 32'({div_by_zero, quotient, remainder}), 32'(0));
    saw_done = 1'b0;
    repeat (W + 4) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(saw_done), 32'(0));

`ifdef DIV_SIGNED_EN
    // Signed specifics: -7/2 and the -8/-1 wrap
    launch(4'b1001, 4'd2, 1'b1);
    wait_done(LAT_N, 1, "sdiv_m7_2");
    launch(4'b1000, 4'b1111, 1'b1);
    wait_done(LAT_N, 1, "sdiv_m8_m1");
`endif

    // Random operands (divisor may be zero)
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      launch(W'(a), W'(b), 1'b1);
      wait_done((b == 0) ? 1 : LAT_N, 1, "rand");
    end

    check("sb_final_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
